ddr3_cmd_responder: RTL and testbench
=====================================

Name: ddr3_cmd_responder

Overview:
Device-side end of the DDR3 command interface. Decodes the {CS#,RAS#,CAS#,WE#} command bus issued by the memory controller, tracks per-bank open/closed state and open row, and enforces basic timing. Emits latency-aligned read/write access strobes to a backing storage model and flags protocol violations. Sits between the controller's command outputs and the memory array model in the DDR3 memory system.

Parameters:
ROW_W, 14, row/column address width (addr bus)
COL_W, 10, column bits taken from addr[COL_W-1:0]
CL, 5, cycles from RD command to rd_strobe (range 2..15)
CWL, 5, cycles from WR command to wr_strobe (range 2..15)
T_RCD, 5, min cycles ACT -> RD/WR, same bank
T_RP, 5, min cycles PRE -> ACT, same bank
T_CCD, 4, min cycles between any two RD/WR commands

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
cke  in  1  clock enable from controller
cmd  in  4  {cs_n,ras_n,cas_n,we_n}
ba  in  3  bank address
addr  in  ROW_W  row (ACT) or column+A10 (RD/WR/PRE)
bank_open  out  8  per-bank active flag
rd_strobe  out  1  one-cycle read access pulse
wr_strobe  out  1  one-cycle write access pulse
acc_bank  out  3  bank of current strobe
acc_row  out  ROW_W  row of current strobe
acc_col  out  COL_W  column of current strobe
self_refresh  out  1  device in self-refresh
err_pulse  out  1  one-cycle violation pulse
err_code  out  3  code of last violation (held until next)

Behaviour:
- Reset: all outputs 0, all banks closed, all timers saturated (no pending timing), pipelines emptied. Reset mid-operation discards in-flight strobes.
- Decode, cmd: 0000 MRS, 0001 REF, 0010 PRE, 0011 ACT, 0100 WR, 0101 RD, 0111 NOP, 1xxx deselect, 0110 reserved (treated as NOP).
- States: ACTIVE_MODE, SELF_REFRESH.
  - ACTIVE_MODE, cke=1: commands execute.
  - ACTIVE_MODE, cke=0: REF with all banks closed -> SELF_REFRESH; any other command is ignored.
  - SELF_REFRESH: self_refresh=1. First cycle with cke=1 -> ACTIVE_MODE. If that cycle's cmd is not NOP/deselect: err 7, command dropped.
- ACT: opens bank ba, stores addr as row, restarts bank tRCD timer.
- PRE: A10=1 closes all banks; A10=0 closes bank ba. Either form restarts tRP timer of each closed bank. PRE to a closed bank is legal (no-op plus timer restart).
- RD/WR: pushes {bank, stored row, addr[COL_W-1:0]} into the read or write delay line. rd_strobe asserts exactly CL cycles after the RD cycle; wr_strobe exactly CWL cycles after the WR cycle. acc_* follow the strobe. When rd_strobe and wr_strobe would coincide, rd has priority on acc_*.
- Delay lines are CL and CWL deep shift registers, so back-to-back legal commands never lose entries.
- MRS, REF (cke=1): REF requires all banks closed. MRS has no effect beyond legality checks.
- Timers: per-bank tRCD and tRP down-counters, global tCCD counter. All saturate at 0. A check passes when the counter is 0, i.e. the command issues ≥T cycles later.
- Error codes; a violating command is dropped entirely (no state change, no strobe):
  - 1: RD/WR to closed bank
  - 2: ACT to open bank
  - 3: tRCD violation
  - 4: tRP violation on ACT
  - 5: REF/MRS/SR-entry with any bank open
  - 6: tCCD violation
  - 7: illegal command on SR exit
  - If several apply, the lowest code wins.
- Error reporting: err_pulse lasts one cycle; err_code is registered with it and holds.
- Auto-precharge: see optional feature.

Optional Feature:
DDR3_RESP_AUTOPRE_EN:
- Defined: RD/WR with A10=1 (RDA/WRA) closes the bank in the same cycle the command is accepted and restarts its tRP timer; the strobe is still issued.
- Undefined: A10 is ignored on RD/WR and the bank stays open.

Test Plan:
- ACT ba=2 row 0x1A3 @c0; RD ba=2 col 0x010 @c5 -> rd_strobe @c10 with acc_bank=2, acc_row=0x1A3, acc_col=0x010; bank_open=0x04.
- ACT ba=1 @c0; WR ba=1 @c3 -> err_pulse @c4 with err_code=3, no wr_strobe ever.
- RD @c10, RD @c12 (same open bank) -> second RD flagged err_code=6. RDs @c10 and @c14 -> strobes @c15 and @c19.
- ACT ba=0 and ba=5; PRE A10=1; ACT ba=5 two cycles later -> err 4. Retry at +5 -> accepted, bank_open=0x20.
- All banks closed, cke=0 with REF -> self_refresh=1. cke=1 with cmd=ACT -> err 7, exit SR, bank_open=0. Repeat with NOP -> clean exit.
- RD pending in delay line, rst asserted mid-latency -> no rd_strobe after release. With DDR3_RESP_AUTOPRE_EN, RD A10=1 -> bank_open bit clears on next cycle and strobe still appears at +CL.

Source files
------------

// File: rtl/ddr3_cmd_responder.sv
// ddr3_cmd_responder: device-side DDR3 command decoder.
// Decodes {cs_n,ras_n,cas_n,we_n}, tracks per-bank open state and open row,
// enforces tRCD / tRP / tCCD, and emits CL/CWL-aligned access strobes toward
// the storage model. Illegal commands are dropped and reported on err_*.
// Optional feature macro: DDR3_RESP_AUTOPRE_EN (RD/WR with A10=1 auto-precharges).
module ddr3_cmd_responder #(
    parameter int ROW_W = 14,
    parameter int COL_W = 10,
    parameter int CL    = 5,
    parameter int CWL   = 5,
    parameter int T_RCD = 5,
    parameter int T_RP  = 5,
    parameter int T_CCD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cke,
    input  logic [3:0]       cmd,
    input  logic [2:0]       ba,
    input  logic [ROW_W-1:0] addr,
    output logic [7:0]       bank_open,
    output logic             rd_strobe,
    output logic             wr_strobe,
    output logic [2:0]       acc_bank,
    output logic [ROW_W-1:0] acc_row,
    output logic [COL_W-1:0] acc_col,
    output logic             self_refresh,
    output logic             err_pulse,
    output logic [2:0]       err_code
);

    localparam int NUM_BANKS = 8;
    localparam int TW        = 8;

    // Command encodings as seen on {cs_n,ras_n,cas_n,we_n}.
    localparam logic [3:0] CMD_MRS = 4'b0000;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_RD  = 4'b0101;

    // Violation codes; numerically lower codes take precedence.
    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_CLOSED    = 3'd1;
    localparam logic [2:0] ERR_ACT_OPEN  = 3'd2;
    localparam logic [2:0] ERR_TRCD      = 3'd3;
    localparam logic [2:0] ERR_TRP       = 3'd4;
    localparam logic [2:0] ERR_BANK_OPEN = 3'd5;
    localparam logic [2:0] ERR_TCCD      = 3'd6;
    localparam logic [2:0] ERR_SR_EXIT   = 3'd7;

    // A timer loaded with T-1 reaches zero exactly T cycles after the command.
    localparam logic [TW-1:0] TRCD_LD = TW'((T_RCD > 0) ? T_RCD - 1 : 0);
    localparam logic [TW-1:0] TRP_LD  = TW'((T_RP  > 0) ? T_RP  - 1 : 0);
    localparam logic [TW-1:0] TCCD_LD = TW'((T_CCD > 0) ? T_CCD - 1 : 0);
    localparam logic [TW-1:0] T_ONE   = TW'(1);

    typedef enum logic [0:0] {
        ACTIVE_MODE  = 1'b0,
        SELF_REFRESH = 1'b1
    } mode_e;

    // One delay-line slot: a pending access and its address.
    typedef struct packed {
        logic             valid;
        logic [2:0]       bank;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } acc_t;

    mode_e             mode_q, mode_d;
    logic              self_refresh_q;
    logic              err_pulse_q;
    logic [2:0]        err_code_q;
    logic [2:0]        err_d;
    logic [7:0]        bank_open_q, bank_open_d;
    logic [TW-1:0]     trcd_q [NUM_BANKS];
    logic [TW-1:0]     trcd_d [NUM_BANKS];
    logic [TW-1:0]     trp_q  [NUM_BANKS];
    logic [TW-1:0]     trp_d  [NUM_BANKS];
    logic [TW-1:0]     tccd_q, tccd_d;
    logic [ROW_W-1:0]  row_q  [NUM_BANKS];
    logic              act_we;
    logic              any_open;
    acc_t              new_entry;
    acc_t              rd_push, wr_push;
    acc_t              rd_pipe_q [CL];
    acc_t              wr_pipe_q [CWL];
    acc_t              acc_sel;

    assign any_open = |bank_open_q;

    // Command decode, legality checks and next-state for banks and timers.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        mode_d      = mode_q;
        err_d       = ERR_NONE;
        bank_open_d = bank_open_q;
        act_we      = 1'b0;
        rd_push     = '0;
        wr_push     = '0;
        tccd_d      = (tccd_q != '0) ? tccd_q - T_ONE : '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            trcd_d[b] = (trcd_q[b] != '0) ? trcd_q[b] - T_ONE : '0;
            trp_d[b]  = (trp_q[b]  != '0) ? trp_q[b]  - T_ONE : '0;
        end
        new_entry.valid = 1'b1;
        new_entry.bank  = ba;
        new_entry.row   = row_q[ba];
        new_entry.col   = addr[COL_W-1:0];

        unique case (mode_q)
            ACTIVE_MODE: begin
                if (cke) begin
                    case (cmd)
                        CMD_MRS, CMD_REF: begin
                            if (any_open) err_d = ERR_BANK_OPEN;
                        end
                        CMD_PRE: begin
                            if (addr[10]) begin
                                bank_open_d = '0;
                                for (int b = 0; b < NUM_BANKS; b++) trp_d[b] = TRP_LD;
                            end else begin
                                bank_open_d[ba] = 1'b0;
                                trp_d[ba]       = TRP_LD;
                            end
                        end
                        CMD_ACT: begin
                            if (bank_open_q[ba])        err_d = ERR_ACT_OPEN;
                            else if (trp_q[ba] != '0)   err_d = ERR_TRP;
                            else begin
                                bank_open_d[ba] = 1'b1;
                                trcd_d[ba]      = TRCD_LD;
                                act_we          = 1'b1;
                            end
                        end
                        CMD_RD, CMD_WR: begin
                            if (!bank_open_q[ba])       err_d = ERR_CLOSED;
                            else if (trcd_q[ba] != '0)  err_d = ERR_TRCD;
                            else if (tccd_q != '0)      err_d = ERR_TCCD;
                            else begin
                                tccd_d = TCCD_LD;
                                if (cmd == CMD_RD) rd_push = new_entry;
                                else               wr_push = new_entry;
`ifdef DDR3_RESP_AUTOPRE_EN
                                if (addr[10]) begin
                                    bank_open_d[ba] = 1'b0;
                                    trp_d[ba]       = TRP_LD;
                                end
`endif
                            end
                        end
                        default: ; // NOP, reserved and deselect do nothing
                    endcase
                end else if (cmd == CMD_REF) begin
                    if (any_open) err_d  = ERR_BANK_OPEN;
                    else          mode_d = SELF_REFRESH;
                end
            end
            SELF_REFRESH: begin
                if (cke) begin
                    mode_d = ACTIVE_MODE;
                    // Only NOP, reserved (NOP-like) or deselect may accompany exit.
                    if (!cmd[3] && (cmd[2:1] != 2'b11)) err_d = ERR_SR_EXIT;
                end
            end
            default: mode_d = ACTIVE_MODE;
        endcase
    end

    // Mode FSM, bank state, timers and registered status/error outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q         <= ACTIVE_MODE;
            self_refresh_q <= 1'b0;
            err_pulse_q    <= 1'b0;
            err_code_q     <= ERR_NONE;
            bank_open_q    <= '0;
            tccd_q         <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                trcd_q[b] <= '0;
                trp_q[b]  <= '0;
            end
        end else begin
            // NOTE: state registers use non-blocking assignment so all update together.
            mode_q         <= mode_d;
            self_refresh_q <= (mode_d == SELF_REFRESH);
            err_pulse_q    <= (err_d != ERR_NONE);
            if (err_d != ERR_NONE) err_code_q <= err_d;
            bank_open_q    <= bank_open_d;
            tccd_q         <= tccd_d;
            for (int b = 0; b < NUM_BANKS; b++) begin
                trcd_q[b] <= trcd_d[b];
                trp_q[b]  <= trp_d[b];
            end
        end
    end

    // Open-row storage, written on each accepted ACT.
    // NOTE: no reset here; a row is only read while its bank is marked open.
    always_ff @(posedge clk) begin
        if (act_we) row_q[ba] <= addr;
    end

    // Read/write latency delay lines; reset empties them so in-flight strobes vanish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CL; i++)  rd_pipe_q[i] <= '0;
            for (int i = 0; i < CWL; i++) wr_pipe_q[i] <= '0;
        end else begin
            rd_pipe_q[0] <= rd_push;
            for (int i = 1; i < CL; i++)  rd_pipe_q[i] <= rd_pipe_q[i-1];
            wr_pipe_q[0] <= wr_push;
            for (int i = 1; i < CWL; i++) wr_pipe_q[i] <= wr_pipe_q[i-1];
        end
    end

    // Access address follows the active strobe, read taking priority.
    always_comb begin
        if (rd_pipe_q[CL-1].valid)       acc_sel = rd_pipe_q[CL-1];
        else if (wr_pipe_q[CWL-1].valid) acc_sel = wr_pipe_q[CWL-1];
        else                             acc_sel = '0;
    end

    assign rd_strobe    = rd_pipe_q[CL-1].valid;
    assign wr_strobe    = wr_pipe_q[CWL-1].valid;
    assign acc_bank     = acc_sel.bank;
    assign acc_row      = acc_sel.row;
    assign acc_col      = acc_sel.col;
    assign bank_open    = bank_open_q;
    assign self_refresh = self_refresh_q;
    assign err_pulse    = err_pulse_q;
    assign err_code     = err_code_q;

endmodule

// File: tb/tb_ddr3_cmd_responder.sv
// Scoreboard bench for ddr3_cmd_responder: stimulus pushes expected strobes and
// error pulses (with the cycle they must appear) into a time-ordered queue; a
// negedge monitor pops and compares whenever the DUT raises a strobe or error.
module tb_ddr3_cmd_responder;

    localparam int ROW_W = 14;
    localparam int COL_W = 10;
    localparam int CL    = 5;
    localparam int CWL   = 5;
    localparam int T_RCD = 5;
    localparam int T_RP  = 5;
    localparam int T_CCD = 4;

    localparam logic [3:0] MRS = 4'b0000;
    localparam logic [3:0] REF = 4'b0001;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] ACT = 4'b0011;
    localparam logic [3:0] WR  = 4'b0100;
    localparam logic [3:0] RD  = 4'b0101;
    localparam logic [3:0] NOP = 4'b0111;

    typedef enum int { EV_RD = 0, EV_WR = 1, EV_ERR = 2 } ev_e;

    typedef struct {
        int               cyc;
        int               kind;
        logic [2:0]       bank;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        logic [2:0]       code;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cke = 1'b1;
    logic [3:0]       cmd = NOP;
    logic [2:0]       ba = '0;
    logic [ROW_W-1:0] addr = '0;
    logic [7:0]       bank_open;
    logic             rd_strobe, wr_strobe, self_refresh, err_pulse;
    logic [2:0]       acc_bank, err_code;
    logic [ROW_W-1:0] acc_row;
    logic [COL_W-1:0] acc_col;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb_q[$];

    ddr3_cmd_responder #(
        .ROW_W(ROW_W), .COL_W(COL_W), .CL(CL), .CWL(CWL),
        .T_RCD(T_RCD), .T_RP(T_RP), .T_CCD(T_CCD)
    ) dut (
        .clk(clk), .rst(rst), .cke(cke), .cmd(cmd), .ba(ba), .addr(addr),
        .bank_open(bank_open), .rd_strobe(rd_strobe), .wr_strobe(wr_strobe),
        .acc_bank(acc_bank), .acc_row(acc_row), .acc_col(acc_col),
        .self_refresh(self_refresh), .err_pulse(err_pulse), .err_code(err_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Insert keeping the queue ordered by cycle, then rd/wr/err within a cycle.
    function automatic void sb_push(input exp_t e);
        int idx = sb_q.size();
        for (int i = 0; i < sb_q.size(); i++) begin
            if (sb_q[i].cyc * 4 + sb_q[i].kind > e.cyc * 4 + e.kind) begin
                idx = i;
                break;
            end
        end
        sb_q.insert(idx, e);
    endfunction

    function automatic void exp_acc(input int kind, input logic [2:0] b,
                                    input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
        exp_t e;
        e.cyc  = cyc + ((kind == EV_RD) ? CL : CWL);
        e.kind = kind;
        e.bank = b;
        e.row  = r;
        e.col  = c;
        e.code = '0;
        sb_push(e);
    endfunction

    function automatic void exp_err(input logic [2:0] code);
        exp_t e;
        e.cyc  = cyc + 1;
        e.kind = EV_ERR;
        e.bank = '0;
        e.row  = '0;
        e.col  = '0;
        e.code = code;
        sb_push(e);
    endfunction

    task automatic sb_match(input int kind, input logic [2:0] b, input logic [ROW_W-1:0] r,
                            input logic [COL_W-1:0] c, input logic [2:0] code);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", kind, cyc);
            return;
        end
        e = sb_q.pop_front();
        check("ev_kind", kind, e.kind);
        check("ev_cycle", cyc, e.cyc);
        if (kind == EV_ERR) begin
            check("err_code", code, e.code);
        end else begin
            check("acc_bank", b, e.bank);
            check("acc_row", r, e.row);
            check("acc_col", c, e.col);
        end
    endtask

    // Monitor: every strobe or error pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (rd_strobe) sb_match(EV_RD, acc_bank, acc_row, acc_col, 3'd0);
            if (wr_strobe && !rd_strobe) sb_match(EV_WR, acc_bank, acc_row, acc_col, 3'd0);
            else if (wr_strobe) sb_match(EV_WR, sb_q.size() > 0 ? sb_q[0].bank : 3'd0,
                                         sb_q.size() > 0 ? sb_q[0].row : '0,
                                         sb_q.size() > 0 ? sb_q[0].col : '0, 3'd0);
            if (err_pulse) sb_match(EV_ERR, '0, '0, '0, err_code);
        end
    end

    // One command for one cycle; returns 1 time unit after the sampling edge.
    task automatic drive(input logic k, input logic [3:0] c, input logic [2:0] b,
                         input logic [ROW_W-1:0] a);
        cke  = k;
        cmd  = c;
        ba   = b;
        addr = a;
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, NOP, 3'd0, '0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_bank_open", bank_open, 8'h00);
        check("rst_self_refresh", self_refresh, 1'b0);
        check("rst_err_code", err_code, 3'd0);
        check("rst_strobes", {rd_strobe, wr_strobe, err_pulse}, 3'b000);
        rst = 1'b0;
        nop(2);

        // Basic ACT -> RD at exactly tRCD; tCCD window on follow-up reads.
        drive(1'b1, ACT, 3'd2, 14'h01A3);
        check("act_bank_open", bank_open, 8'h04);
        nop(4);
        exp_acc(EV_RD, 3'd2, 14'h01A3, 10'h010);
        drive(1'b1, RD, 3'd2, 14'h0010);
        nop(4);
        exp_acc(EV_RD, 3'd2, 14'h01A3, 10'h020);
        drive(1'b1, RD, 3'd2, 14'h0020);
        nop(1);
        exp_err(3'd6);
        drive(1'b1, RD, 3'd2, 14'h0030);
        nop(1);
        exp_acc(EV_RD, 3'd2, 14'h01A3, 10'h040);
        drive(1'b1, RD, 3'd2, 14'h0040);
        nop(8);

        // tRCD violation, legal WR at the boundary, closed-bank and open-bank errors.
        drive(1'b1, ACT, 3'd1, 14'h00F0);
        nop(2);
        exp_err(3'd3);
        drive(1'b1, WR, 3'd1, 14'h0007);
        nop(1);
        exp_acc(EV_WR, 3'd1, 14'h00F0, 10'h055);
        drive(1'b1, WR, 3'd1, 14'h0055);
        exp_err(3'd1);
        drive(1'b1, WR, 3'd6, 14'h0011);
        exp_err(3'd2);
        drive(1'b1, ACT, 3'd1, 14'h0001);
        check("bank_open_1_2", bank_open, 8'h06);
        nop(6);

        // tRP: precharge-all, early ACT rejected, retry at +T_RP accepted.
        drive(1'b1, PRE, 3'd0, 14'h0400);
        check("pre_all_closed", bank_open, 8'h00);
        nop(4);
        drive(1'b1, ACT, 3'd0, 14'h0123);
        drive(1'b1, ACT, 3'd5, 14'h0222);
        drive(1'b1, PRE, 3'd0, 14'h0400);
        nop(1);
        exp_err(3'd4);
        drive(1'b1, ACT, 3'd5, 14'h0155);
        nop(2);
        drive(1'b1, ACT, 3'd5, 14'h0155);
        check("trp_retry_open", bank_open, 8'h20);
        // PRE to a closed bank restarts its tRP timer.
        drive(1'b1, PRE, 3'd3, 14'h0000);
        nop(3);
        exp_err(3'd4);
        drive(1'b1, ACT, 3'd3, 14'h0333);
        drive(1'b1, ACT, 3'd3, 14'h0333);
        check("pre_closed_then_act", bank_open, 8'h28);

        // REF/MRS with banks open, ignored command under cke=0, self-refresh entry/exit.
        exp_err(3'd5);
        drive(1'b1, REF, 3'd0, '0);
        exp_err(3'd5);
        drive(1'b1, MRS, 3'd0, '0);
        drive(1'b0, ACT, 3'd0, 14'h0777);
        check("cke_low_ignored", bank_open, 8'h28);
        exp_err(3'd5);
        drive(1'b0, REF, 3'd0, '0);
        check("sr_entry_refused", self_refresh, 1'b0);
        drive(1'b1, PRE, 3'd0, 14'h0400);
        nop(4);
        drive(1'b0, REF, 3'd0, '0);
        check("sr_entered", self_refresh, 1'b1);
        drive(1'b0, NOP, 3'd0, '0);
        drive(1'b0, NOP, 3'd0, '0);
        check("sr_held", self_refresh, 1'b1);
        exp_err(3'd7);
        drive(1'b1, ACT, 3'd0, 14'h0044);
        check("sr_exit_err_sr", self_refresh, 1'b0);
        check("sr_exit_err_banks", bank_open, 8'h00);
        nop(1);
        drive(1'b0, REF, 3'd0, '0);
        check("sr_reentered", self_refresh, 1'b1);
        drive(1'b1, NOP, 3'd0, '0);
        check("sr_clean_exit", self_refresh, 1'b0);
        nop(6);

        // Reset while a read is in the delay line discards the strobe.
        drive(1'b1, ACT, 3'd4, 14'h02BC);
        nop(4);
        drive(1'b1, RD, 3'd4, 14'h00AB);
        nop(2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_bank_open", bank_open, 8'h00);
        check("midrst_err_code", err_code, 3'd0);
        rst = 1'b0;
        nop(8);
        check("midrst_sb_empty", sb_q.size(), 0);

        // RD with A10=1: auto-precharge when enabled, plain read otherwise.
        drive(1'b1, ACT, 3'd6, 14'h00AA);
        nop(4);
        exp_acc(EV_RD, 3'd6, 14'h00AA, 10'h012);
        drive(1'b1, RD, 3'd6, 14'h0412);
`ifdef DDR3_RESP_AUTOPRE_EN
        check("autopre_closed", bank_open, 8'h00);
        exp_err(3'd4);
`else
        check("a10_ignored_open", bank_open, 8'h40);
        exp_err(3'd2);
`endif
        drive(1'b1, ACT, 3'd6, 14'h00BB);
        nop(10);

        check("sb_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
